// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle divider.
// Zero divisors and divider timeouts complete with q=all-ones and err=1.
module div_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [31:0] q,
  output logic [1:0]  done,
  output logic        err,
  output logic        busy,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic        div_ready,
  input  logic [31:0] div_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic [31:0] q_q, q_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        pick;
  logic [31:0] pick_a;
  logic [31:0] pick_b;

  // On a tie the requester not served last wins; a lone requester always wins.
  assign pick   = (req0 && req1) ? ~last_q : req1;
  assign pick_a = pick ? a1 : a0;
  assign pick_b = pick ? b1 : b0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    q_d     = q_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = pick;
          div_a_d = pick_a;
          div_b_d = pick_b;
          if (pick_b == 32'h0) begin
            q_d     = 32'hFFFF_FFFF;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // WAIT lasts at most TIMEOUT cycles; the last one gives up.
        if (div_ready) begin
          q_d     = div_q;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          q_d     = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      div_a_q <= 32'h0;
      div_b_q <= 32'h0;
      q_q     <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      q_q     <= q_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q         = q_q;
  assign err       = err_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign busy      = (state_q != IDLE);
  assign div_start = (state_q == START);
  assign done      = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
